// File: rtl/spi_target_pkg.sv
// Shared types for the SPI mode-0 target.
package spi_target_pkg;
  typedef enum logic [1:0] {WAIT_IDLE, IDLE, SHIFT} state_e;
endpackage

// File: rtl/spi_target_sync_edge_det.sv
// Multi-flop input synchroniser with registered rise/fall pulse detection.
module sync_edge_det #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic sync,
  output logic rise,
  output logic fall
);
  logic [STAGES-1:0] chain_q, chain_d;
  logic prev_q, prev_d;
  logic rise_q, rise_d;
  logic fall_q, fall_d;

  always_comb begin
    chain_d = {chain_q[STAGES-2:0], din};
    prev_d  = chain_q[STAGES-1];
    rise_d  = chain_q[STAGES-1] & ~prev_q;
    fall_d  = ~chain_q[STAGES-1] & prev_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      chain_q <= {STAGES{RESET_VAL}};
      prev_q  <= RESET_VAL;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      chain_q <= chain_d;
      prev_q  <= prev_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign sync = chain_q[STAGES-1];
  assign rise = rise_q;
  assign fall = fall_q;
endmodule

// File: rtl/spi_target.sv
// SPI mode-0 target: oversampled pins, MSB-first RX deserialiser and back-to-back TX serialiser.
module spi_target
  import spi_target_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sclk,
  input  logic             cs_n,
  input  logic             mosi,
  output logic             miso,
  output logic             miso_oe,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic             tx_underrun,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  output logic             busy
);
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam int SW = $clog2(SYNC_STAGES + 1);
  localparam logic [CW-1:0] LAST   = CW'(WIDTH - 1);
  localparam logic [SW-1:0] SETTLE = SW'(SYNC_STAGES);

  logic sclk_rise, sclk_fall, sclk_lvl_unused;
  logic cs_sync, cs_rise, cs_fall;
  logic mosi_sync, mosi_rise_unused, mosi_fall_unused;

  sync_edge_det #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sclk (
    .clk(clk), .rst(rst), .din(sclk),
    .sync(sclk_lvl_unused), .rise(sclk_rise), .fall(sclk_fall));
  sync_edge_det #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs (
    .clk(clk), .rst(rst), .din(cs_n),
    .sync(cs_sync), .rise(cs_rise), .fall(cs_fall));
  sync_edge_det #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_mosi (
    .clk(clk), .rst(rst), .din(mosi),
    .sync(mosi_sync), .rise(mosi_rise_unused), .fall(mosi_fall_unused));

  state_e           state_q, state_d;
  logic [SW-1:0]    settle_q, settle_d;
  logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] tx_shift_q, tx_shift_d;
  logic [WIDTH-1:0] rx_shift_q, rx_shift_d;
  logic [WIDTH-1:0] rx_data_q, rx_data_d;
  logic             rx_valid_q, rx_valid_d;
  logic             tx_ready_q, tx_ready_d;
  logic             tx_underrun_q, tx_underrun_d;
  logic             miso_q, miso_d;
  logic             do_load;

  always_comb begin
    state_d       = state_q;
    settle_d      = settle_q;
    bit_cnt_d     = bit_cnt_q;
    done_d        = done_q;
    tx_shift_d    = tx_shift_q;
    rx_shift_d    = rx_shift_q;
    rx_data_d     = rx_data_q;
    rx_valid_d    = 1'b0;
    tx_ready_d    = 1'b0;
    tx_underrun_d = 1'b0;
    miso_d        = miso_q;
    do_load       = 1'b0;

    case (state_q)
      // Synchroniser reset values are not real pin samples; let them flush
      // before trusting the cs_n level, so a fake fall cannot start a frame.
      WAIT_IDLE: begin
        if (settle_q != SETTLE) settle_d = settle_q + SW'(1);
        else if (cs_sync)       state_d  = IDLE;
      end
      IDLE: begin
        if (cs_fall) begin
          state_d    = SHIFT;
          do_load    = 1'b1;
          bit_cnt_d  = '0;
          done_d     = 1'b0;
          rx_shift_d = '0;
        end
      end
      SHIFT: begin
        if (cs_rise) begin
          state_d    = IDLE;
          bit_cnt_d  = '0;
          done_d     = 1'b0;
          tx_shift_d = '0;
          miso_d     = 1'b0;
        end else if (sclk_rise) begin
          rx_shift_d = {rx_shift_q[WIDTH-2:0], mosi_sync};
          if (bit_cnt_q == LAST) begin
            bit_cnt_d  = '0;
            done_d     = 1'b1;
            rx_data_d  = {rx_shift_q[WIDTH-2:0], mosi_sync};
            rx_valid_d = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + CW'(1);
          end
        end else if (sclk_fall) begin
          if (bit_cnt_q == '0 && done_q) begin
            do_load = 1'b1;
          end else begin
            tx_shift_d = {tx_shift_q[WIDTH-2:0], 1'b0};
            miso_d     = tx_shift_q[WIDTH-2];
          end
        end
      end
      default: state_d = WAIT_IDLE;
    endcase

    if (do_load) begin
      if (tx_valid) begin
        tx_shift_d = tx_data;
        miso_d     = tx_data[WIDTH-1];
        tx_ready_d = 1'b1;
      end else begin
        tx_shift_d    = '0;
        miso_d        = 1'b0;
        tx_underrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= WAIT_IDLE;
      settle_q      <= '0;
      bit_cnt_q     <= '0;
      done_q        <= 1'b0;
      tx_shift_q    <= '0;
      rx_shift_q    <= '0;
      rx_data_q     <= '0;
      rx_valid_q    <= 1'b0;
      tx_ready_q    <= 1'b0;
      tx_underrun_q <= 1'b0;
      miso_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      settle_q      <= settle_d;
      bit_cnt_q     <= bit_cnt_d;
      done_q        <= done_d;
      tx_shift_q    <= tx_shift_d;
      rx_shift_q    <= rx_shift_d;
      rx_data_q     <= rx_data_d;
      rx_valid_q    <= rx_valid_d;
      tx_ready_q    <= tx_ready_d;
      tx_underrun_q <= tx_underrun_d;
      miso_q        <= miso_d;
    end
  end

  assign busy        = (state_q == SHIFT);
  assign miso_oe     = busy;
  assign miso        = miso_q;
  assign tx_ready    = tx_ready_q;
  assign tx_underrun = tx_underrun_q;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
endmodule

// File: tb/tb_spi_target.sv
// Directed bench for spi_target: frame vector table plus abort/reset/collision sequences.
module tb_spi_target;
  localparam int HALF = 25;

  logic       clk = 1'b0, rst = 1'b1;
  logic       sclk = 1'b0, cs_n = 1'b1, mosi = 1'b0;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data;
  logic       miso, miso_oe, tx_ready, tx_underrun, rx_valid, busy;
  logic [7:0] rx_data;

  spi_target #(.WIDTH(8), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
    .miso(miso), .miso_oe(miso_oe), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .tx_underrun(tx_underrun), .rx_data(rx_data),
    .rx_valid(rx_valid), .busy(busy));

  always #10 clk = ~clk;

  int         rx_cnt = 0, rdy_cnt = 0, unr_cnt = 0;
  logic [7:0] rx_log [64];
  always @(negedge clk) begin
    if (rx_valid) begin
      rx_log[rx_cnt[5:0]] <= rx_data;
      rx_cnt <= rx_cnt + 1;
    end
    if (tx_ready)    rdy_cnt <= rdy_cnt + 1;
    if (tx_underrun) unr_cnt <= unr_cnt + 1;
  end

  // Next TX word advances with each consumed word of the current frame.
  logic [7:0] tx_q [3];
  int         rdy_base = 0;
  int         tx_sel;
  assign tx_sel  = (rdy_cnt - rdy_base > 2) ? 2 : (rdy_cnt - rdy_base);
  assign tx_data = tx_q[tx_sel];

  int checks = 0, errors = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic frame(input int nbits, input logic [23:0] mo, input bit simul,
                       output logic [23:0] mi, output logic busy_mid);
    mi = '0;
    busy_mid = 1'b0;
    cs_n = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      mosi = mo[23-i];
      wait_n(HALF);
      mi[23-i] = miso;
      if (i == 0) busy_mid = busy;
      sclk = 1'b1;
      if (i == nbits - 1 && simul) cs_n = 1'b1;
      wait_n(HALF);
      if (i != nbits - 1) sclk = 1'b0;
    end
    if (!simul) begin
      cs_n = 1'b1;
      wait_n(HALF);
    end
    sclk = 1'b0;
    mosi = 1'b0;
    wait_n(HALF);
  endtask

  typedef struct {
    int          nw;
    logic [23:0] tx;
    logic        txv;
    logic [23:0] mo;
    logic [23:0] exp_rx;
    logic [23:0] exp_mi;
    int          exp_rdy;
    int          exp_unr;
  } vec_t;

  vec_t        vt [4];
  logic [23:0] mi;
  logic        bm;
  int          rx0, rdy0, unr0;

  task automatic snap();
    rx0 = rx_cnt; rdy0 = rdy_cnt; unr0 = unr_cnt; rdy_base = rdy_cnt;
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_oe"},   miso_oe, 0);
    chk({tag, "_miso"}, miso, 0);
  endtask

  initial begin
    vt[0] = '{1, 24'hA50000, 1'b1, 24'h3C0000, 24'h3C0000, 24'hA50000, 1, 0};
    vt[1] = '{3, 24'h010203, 1'b1, 24'hF00FAA, 24'hF00FAA, 24'h010203, 3, 0};
    vt[2] = '{1, 24'hFF0000, 1'b0, 24'h960000, 24'h960000, 24'h000000, 0, 1};
    vt[3] = '{2, 24'h7E8100, 1'b1, 24'h5AC300, 24'h5AC300, 24'h7E8100, 2, 0};
    tx_q[0] = 8'h00; tx_q[1] = 8'h00; tx_q[2] = 8'h00;

    wait_n(4);
    chk("rst_miso", miso, 0);
    chk("rst_oe", miso_oe, 0);
    chk("rst_ready", tx_ready, 0);
    chk("rst_unr", tx_underrun, 0);
    chk("rst_rxdata", rx_data, 0);
    chk("rst_rxvalid", rx_valid, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;
    wait_n(10);

    foreach (vt[v]) begin
      tx_q[0] = vt[v].tx[23:16]; tx_q[1] = vt[v].tx[15:8]; tx_q[2] = vt[v].tx[7:0];
      tx_valid = vt[v].txv;
      snap();
      frame(8 * vt[v].nw, vt[v].mo, 1'b0, mi, bm);
      chk($sformatf("v%0d_busy_mid", v), bm, 1);
      chk($sformatf("v%0d_rxcnt", v), rx_cnt - rx0, vt[v].nw);
      for (int k = 0; k < vt[v].nw; k++)
        chk($sformatf("v%0d_rx%0d", v, k), rx_log[(rx0 + k) % 64], vt[v].exp_rx[23-8*k -: 8]);
      chk($sformatf("v%0d_miso", v), mi, vt[v].exp_mi);
      chk($sformatf("v%0d_ready", v), rdy_cnt - rdy0, vt[v].exp_rdy);
      chk($sformatf("v%0d_unr", v), unr_cnt - unr0, vt[v].exp_unr);
      check_idle($sformatf("v%0d_end", v));
      wait_n(HALF);
    end

    // Abort after 5 bits, then a full frame.
    tx_q[0] = 8'hA5; tx_valid = 1'b1;
    snap();
    frame(5, 24'h5A0000, 1'b0, mi, bm);
    chk("abort_rxcnt", rx_cnt - rx0, 0);
    check_idle("abort");
    wait_n(HALF);
    snap();
    frame(8, 24'h5A0000, 1'b0, mi, bm);
    chk("abort_next_rxcnt", rx_cnt - rx0, 1);
    chk("abort_next_rx", rx_log[rx0 % 64], 8'h5A);
    chk("abort_next_miso", mi[23:16], 8'hA5);
    wait_n(HALF);

    // Reset mid-word, released while cs_n is still low.
    tx_q[0] = 8'h3C;
    snap();
    cs_n = 1'b0;
    wait_n(HALF);
    for (int i = 0; i < 3; i++) begin
      sclk = 1'b1; wait_n(HALF); sclk = 1'b0; wait_n(HALF);
    end
    sclk = 1'b1;
    wait_n(5);
    rst = 1'b1;
    wait_n(3);
    rst = 1'b0;
    snap();
    wait_n(HALF);
    for (int i = 0; i < 8; i++) begin
      sclk = 1'b0; wait_n(HALF); sclk = 1'b1; wait_n(HALF);
    end
    sclk = 1'b0;
    wait_n(HALF);
    chk("rstmid_rxcnt", rx_cnt - rx0, 0);
    chk("rstmid_ready", rdy_cnt - rdy0, 0);
    chk("rstmid_unr", unr_cnt - unr0, 0);
    check_idle("rstmid");
    cs_n = 1'b1;
    wait_n(2 * HALF);
    snap();
    frame(8, 24'hC30000, 1'b0, mi, bm);
    chk("rstmid_next_rxcnt", rx_cnt - rx0, 1);
    chk("rstmid_next_rx", rx_log[rx0 % 64], 8'hC3);
    chk("rstmid_next_miso", mi[23:16], 8'h3C);
    chk("rstmid_next_ready", rdy_cnt - rdy0, 1);
    wait_n(HALF);

    // cs_n rise coincident with the 8th sclk rise: cs_n wins.
    tx_q[0] = 8'hA5;
    snap();
    frame(8, 24'h3C0000, 1'b1, mi, bm);
    chk("simul_rxcnt", rx_cnt - rx0, 0);
    chk("simul_ready", rdy_cnt - rdy0, 1);
    chk("simul_unr", unr_cnt - unr0, 0);
    chk("simul_miso", mi[23:16], 8'hA5);
    check_idle("simul");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/spi_target.md
# spi_target

SPI responder (target) for mode 0 (CPOL=0, CPHA=0), MSB first, oversampled on the system clock. It pairs with an SPI initiator elsewhere on the board. It resynchronises the external SCLK/CS_N/MOSI pins into the `clk` domain and deserialises MOSI into parallel words. It also serialises parallel transmit words onto MISO, with continuous back-to-back words while CS_N stays low.

## Interface
Parameters:
- WIDTH, 8, word length in bits (≥2)
- SYNC_STAGES, 2, flip-flop stages per input synchroniser (≥2)

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- sclk  in  1  SPI clock, asynchronous to clk
- cs_n  in  1  chip select, active-low, asynchronous
- mosi  in  1  serial data in, asynchronous
- miso  out  1  serial data out, registered
- miso_oe  out  1  high while the transfer is selected; the pad tristates when low
- tx_data  in  WIDTH  next word to transmit
- tx_valid  in  1  tx_data is valid
- tx_ready  out  1  one-cycle pulse: tx_data is consumed this cycle
- tx_underrun  out  1  one-cycle pulse: a word was needed while tx_valid was low
- rx_data  out  WIDTH  last complete received word, held until the next one
- rx_valid  out  1  one-cycle pulse: rx_data was updated
- busy  out  1  high in state SHIFT

## Operation
- Each of sclk, cs_n and mosi passes through SYNC_STAGES flops. sclk and cs_n then get a registered edge detector producing rise/fall pulses.
- States:
  - WAIT_IDLE: entered at reset. Moves to IDLE once synced cs_n=1. This blocks a start in the middle of a frame.
  - IDLE: on cs_n fall, loads the TX word and goes to SHIFT.
  - SHIFT: transfers bits. Returns to IDLE on cs_n rise.
- TX word load happens at cs_n fall and again at every sclk fall after the WIDTH-th bit:
  - If tx_valid=1: tx_shift<=tx_data and tx_ready pulses.
  - If tx_valid=0: tx_shift<=0 and tx_underrun pulses.
  - miso<=MSB of the loaded word.
- In SHIFT, on sclk rise:
  - rx_shift<={rx_shift[WIDTH-2:0], mosi_sync}.
  - bit_cnt increments. bit_cnt is $clog2(WIDTH) bits wide and wraps to 0 after WIDTH-1.
  - When the WIDTH-th bit is captured, rx_data<=completed word and rx_valid pulses.
- In SHIFT, on sclk fall: a load happens if bit_cnt==0 and at least one word has completed; otherwise tx_shift shifts left and miso<=new MSB.
- On cs_n rise mid-word:
  - The partial RX word is discarded with no rx_valid.
  - bit_cnt clears and the state returns to IDLE.
  - miso_oe drops and tx_shift content is lost; no tx_ready is issued.
- There is no RX backpressure. The consumer must take rx_data within WIDTH sclk periods.

## Timing
- Reset values: miso=0, miso_oe=0, tx_ready=0, tx_underrun=0, rx_data=0, rx_valid=0, busy=0, state=WAIT_IDLE. Synchroniser chains reset to cs_n=1, sclk=0, mosi=0.
- Pin-to-action latency: SYNC_STAGES+1 clk cycles from a pin edge to its detected pulse. State, shift and flag updates occur on the edge following the pulse.
- rx_valid asserts SYNC_STAGES+2 cycles after the WIDTH-th sclk rise on the pin.
- miso changes SYNC_STAGES+2 cycles after an sclk fall or cs_n fall on the pin.
- Requirement: sclk high and low phases each ≥ SYNC_STAGES+3 clk periods. The first sclk rise must come ≥ SYNC_STAGES+3 clk periods after cs_n fall.
- Event priority:
  - cs_n rise in the same cycle as an sclk edge: cs_n wins and the sclk edge is ignored.
  - rst overrides everything.
- rst mid-transfer: returns to WAIT_IDLE. No pulses are emitted until cs_n is seen high and then falls.

## Structure
- Package spi_target_pkg holds the state enum (WAIT_IDLE, IDLE, SHIFT).
- Sub-module sync_edge_det (parameter STAGES, RESET_VAL): synchroniser plus rise/fall pulse outputs. Instanced for sclk and cs_n; mosi uses the same module with the pulse outputs unused.

## Test plan
- Single word, WIDTH=8: tx_data=0xA5 held valid; initiator sends MOSI 0x3C with a 1 MHz sclk on a 50 MHz clk, cs_n low for 8 bits → MISO bits 1,0,1,0,0,1,0,1; one tx_ready; rx_data=0x3C; one rx_valid; busy falls after cs_n rise.
- Back-to-back: 3 words under one cs_n, TX 0x01,0x02,0x03, MOSI 0xF0,0x0F,0xAA → 3 tx_ready pulses, RX sequence matches in order, no underrun.
- Underrun: tx_valid=0 at cs_n fall → tx_underrun pulses once; MISO reads 0x00; RX still captures correctly.
- Abort: cs_n rises after 5 bits → no rx_valid, state IDLE; the next full frame receives 0x5A correctly.
- Reset: rst asserted mid-word, released with cs_n low → no activity until cs_n goes high then low; the following frame is correct.
- Simultaneous: cs_n rise aligned with the 8th sclk rise at the synchronised level → no rx_valid; all outputs at idle values.
